// File: rtl/rmii_to_mii.sv
// RMII receive path: CRS_DV + RXD[1:0] dibits at 50 MHz rebuilt into MII-style nibbles,
// each presented with a one-cycle rx_en strobe. Optional preamble/SFD stripping.
module rmii_to_mii #(
  parameter bit STRIP_PREAMBLE = 1'b0
) (
  input  logic       eth_rmii_clk,
  input  logic       sys_rst_n,
  input  logic       eth_rx_dv,
  input  logic [1:0] eth_rx_data,
  output logic       rx_dv,
  output logic       rx_en,
  output logic [3:0] rx_data,
  output logic       rx_er,
  output logic       crs
);

  typedef enum logic [1:0] {IDLE, WAIT_PRE, ASSEMBLE} state_t;
  typedef enum logic [1:0] {SFD_HUNT, SFD_SEEN5, SFD_PASS, SFD_DROP} sfd_t;

  state_t     state;
  sfd_t       sfd;
  logic       dv_r;
  logic [1:0] rxd_r;
  logic [1:0] lo;
  logic       phase;
  logic       dv0;
  logic       armed;
  logic [3:0] nibble;

  // Second dibit of the nibble is the one currently in rxd_r (LSB-first order).
  assign nibble = {rxd_r, lo};

  always_ff @(posedge eth_rmii_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      // NOTE: dv_r resets to 1 so the reset value itself cannot count as the
      // dv=0 sample IDLE needs before it may lock onto a new frame.
      dv_r    <= 1'b1;
      rxd_r   <= 2'b00;
      state   <= IDLE;
      sfd     <= SFD_HUNT;
      lo      <= 2'b00;
      phase   <= 1'b0;
      dv0     <= 1'b0;
      armed   <= 1'b0;
      rx_dv   <= 1'b0;
      rx_en   <= 1'b0;
      rx_data <= 4'h0;
      rx_er   <= 1'b0;
      crs     <= 1'b0;
    end else begin
      dv_r  <= eth_rx_dv;
      rxd_r <= eth_rx_data;
      rx_en <= 1'b0;
      rx_er <= 1'b0;

      case (state)
        IDLE: begin
          rx_dv <= 1'b0;
          crs   <= 1'b0;
          phase <= 1'b0;
          if (!dv_r) begin
            armed <= 1'b1;
          end else if (armed) begin
            state <= WAIT_PRE;
          end
        end

        WAIT_PRE: begin
          if (!dv_r) begin
            state <= IDLE;
          end else if (rxd_r == 2'b01) begin
            // First preamble dibit fixes nibble alignment: it is phase 0.
            lo    <= rxd_r;
            dv0   <= 1'b1;
            crs   <= 1'b1;
            phase <= 1'b1;
            sfd   <= STRIP_PREAMBLE ? SFD_HUNT : SFD_PASS;
            state <= ASSEMBLE;
          end
        end

        ASSEMBLE: begin
          if (!phase) begin
            lo    <= rxd_r;
            dv0   <= dv_r;
            crs   <= dv_r;
            phase <= 1'b1;
          end else if (dv_r) begin
            phase <= 1'b0;
            unique case (sfd)
              SFD_PASS: begin
                rx_data <= nibble;
                rx_en   <= 1'b1;
                rx_dv   <= 1'b1;
              end
              SFD_HUNT:  sfd <= (nibble == 4'h5) ? SFD_SEEN5 : SFD_DROP;
              SFD_SEEN5: begin
                if (nibble == 4'hD) begin
                  sfd <= SFD_PASS;
                end else if (nibble != 4'h5) begin
                  sfd <= SFD_DROP;
                end
              end
              SFD_DROP:  sfd <= SFD_DROP;
            endcase
          end else begin
            // CRS_DV low on phase 1: end of frame; high-then-low is a misaligned end.
            rx_er <= dv0;
            rx_dv <= 1'b0;
            crs   <= 1'b0;
            phase <= 1'b0;
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rmii_to_mii.sv
// Self-checking bench for rmii_to_mii: one instance per STRIP_PREAMBLE setting on shared
// inputs; the driver pushes expected nibbles (value, cycle, crs) and a monitor pops them.
module tb_rmii_to_mii;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       dv = 1'b0;
  logic [1:0] rxd = 2'b00;

  logic       rx_dv0, rx_en0, rx_er0, crs0;
  logic [3:0] rx_data0;
  logic       rx_dv1, rx_en1, rx_er1, crs1;
  logic [3:0] rx_data1;

  rmii_to_mii #(.STRIP_PREAMBLE(1'b0)) dut0 (
    .eth_rmii_clk(clk), .sys_rst_n(rst_n), .eth_rx_dv(dv), .eth_rx_data(rxd),
    .rx_dv(rx_dv0), .rx_en(rx_en0), .rx_data(rx_data0), .rx_er(rx_er0), .crs(crs0)
  );

  rmii_to_mii #(.STRIP_PREAMBLE(1'b1)) dut1 (
    .eth_rmii_clk(clk), .sys_rst_n(rst_n), .eth_rx_dv(dv), .eth_rx_data(rxd),
    .rx_dv(rx_dv1), .rx_en(rx_en1), .rx_data(rx_data1), .rx_er(rx_er1), .crs(crs1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0] nib;
    int         at;
    logic       crs;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int   checks = 0;
  int   errors = 0;
  int   er_cnt0 = 0, er_cnt1 = 0;
  int   en_cnt0 = 0, en_cnt1 = 0;
  int   dvhi0 = 0, dvhi1 = 0;
  int   rise0 = 0, rise1 = 0;
  logic prev_en0 = 1'b0, prev_en1 = 1'b0;
  logic prev_dv0 = 1'b0, prev_dv1 = 1'b0;

  // ---------------- driver ----------------
  task automatic drive_dibit(input logic [1:0] d, input logic v);
    @(negedge clk);
    rxd = d;
    dv  = v;
  endtask

  // Second dibit sampled at the next posedge; nibble strobe registered one edge later.
  task automatic drive_nib(input logic [3:0] n, input logic v0, input logic v1,
                           input bit p0, input bit p1);
    drive_dibit(n[1:0], v0);
    drive_dibit(n[3:2], v1);
    if (p0) q0.push_back(exp_t'{n, cyc + 2, v0});
    if (p1) q1.push_back(exp_t'{n, cyc + 2, v0});
  endtask

  task automatic send_preamble();
    for (int i = 0; i < 3; i++) drive_dibit(2'b00, 1'b1);
    for (int i = 0; i < 5; i++) drive_nib(4'h5, 1'b1, 1'b1, 1'b1, 1'b0);
    drive_nib(4'hD, 1'b1, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    drive_nib(b[3:0], 1'b1, 1'b1, 1'b1, 1'b1);
    drive_nib(b[7:4], 1'b1, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_dibit(2'b00, 1'b0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  task automatic check_strobe(input int id, input logic [3:0] data, input logic dvl,
                              input logic c, input logic pe);
    exp_t e;
    checks++;
    if ((id == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
      errors++;
      $display("FAIL strobe%0d unexpected nibble %h at cycle %0d, required no strobe",
               id, data, cyc);
    end else begin
      e = (id == 0) ? q0.pop_front() : q1.pop_front();
      if (data !== e.nib || dvl !== 1'b1 || c !== e.crs || pe !== 1'b0 || cyc != e.at) begin
        errors++;
        $display("FAIL strobe%0d got nib=%h dv=%b crs=%b prev_en=%b cyc=%0d, required nib=%h dv=1 crs=%b prev_en=0 cyc=%0d",
                 id, data, dvl, c, pe, cyc, e.nib, e.crs, e.at);
      end
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (rx_en0) begin
        check_strobe(0, rx_data0, rx_dv0, crs0, prev_en0);
        en_cnt0++;
      end
      if (rx_en1) begin
        check_strobe(1, rx_data1, rx_dv1, crs1, prev_en1);
        en_cnt1++;
      end
      if (rx_er0) er_cnt0++;
      if (rx_er1) er_cnt1++;
      if (rx_dv0) dvhi0++;
      if (rx_dv1) dvhi1++;
      if (rx_dv0 && !prev_dv0) rise0++;
      if (rx_dv1 && !prev_dv1) rise1++;
      prev_en0 = rx_en0;
      prev_en1 = rx_en1;
      prev_dv0 = rx_dv0;
      prev_dv1 = rx_dv1;
    end
  endtask

  task automatic watchdog();
    #500000;
    $display("FAIL watchdog simulation did not finish, required completion");
    $fatal(1, "watchdog");
  endtask

  task automatic expect_int(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s got %0d required %0d", name, got, req);
    end
  endtask

  task automatic expect_drained(input string name);
    expect_int({name, "_q0_left"}, q0.size(), 0);
    expect_int({name, "_q1_left"}, q1.size(), 0);
    expect_int({name, "_rx_dv0_end"}, int'(rx_dv0), 0);
    expect_int({name, "_rx_dv1_end"}, int'(rx_dv1), 0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({rx_dv0, rx_en0, rx_data0, rx_er0, crs0} !== 8'h00) begin
      errors++;
      $display("FAIL reset_dut0 got %b required 00000000",
               {rx_dv0, rx_en0, rx_data0, rx_er0, crs0});
    end
    checks++;
    if ({rx_dv1, rx_en1, rx_data1, rx_er1, crs1} !== 8'h00) begin
      errors++;
      $display("FAIL reset_dut1 got %b required 00000000",
               {rx_dv1, rx_en1, rx_data1, rx_er1, crs1});
    end
    rst_n = 1'b1;
    idle(4);
  endtask

  task automatic test_basic();
    int e0 = en_cnt0, e1 = en_cnt1, r0 = er_cnt0;
    dvhi0 = 0;
    dvhi1 = 0;
    send_preamble();
    send_byte(8'hA7);
    idle(6);
    expect_drained("basic");
    expect_int("basic_strobes0", en_cnt0 - e0, 8);
    expect_int("basic_strobes1", en_cnt1 - e1, 2);
    expect_int("basic_dv_cycles0", dvhi0, 16);
    expect_int("basic_dv_cycles1", dvhi1, 4);
    expect_int("basic_rx_er0", er_cnt0 - r0, 0);
  endtask

  task automatic test_strip();
    int e1 = en_cnt1, r1 = er_cnt1;
    dvhi1 = 0;
    send_preamble();
    send_byte(8'hA7);
    idle(6);
    expect_drained("strip");
    expect_int("strip_strobes1", en_cnt1 - e1, 2);
    expect_int("strip_dv_cycles1", dvhi1, 4);
    expect_int("strip_rx_er1", er_cnt1 - r1, 0);
  endtask

  task automatic test_end_toggle();
    int r0 = er_cnt0, r1 = er_cnt1;
    send_preamble();
    send_byte(8'hA7);
    drive_nib(4'hC, 1'b0, 1'b1, 1'b1, 1'b1);
    drive_nib(4'h3, 1'b0, 1'b1, 1'b1, 1'b1);
    idle(6);
    expect_drained("toggle");
    expect_int("toggle_rx_er0", er_cnt0 - r0, 0);
    expect_int("toggle_rx_er1", er_cnt1 - r1, 0);
  endtask

  task automatic test_illegal_end();
    int  r0 = er_cnt0, r1 = er_cnt1;
    int  at;
    bit  seen = 1'b0;
    send_preamble();
    send_byte(8'hA7);
    drive_dibit(2'b00, 1'b1);
    drive_dibit(2'b11, 1'b0);
    at = cyc + 2;
    drive_dibit(2'b00, 1'b0);
    for (int i = 0; i < 8 && !seen; i++) begin
      if (i > 0) @(negedge clk);
      if (rx_er0) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL illegal_rx_er timeout waiting for rx_er pulse, required pulse at cycle %0d", at);
    end else if (cyc != at || rx_dv0 !== 1'b0 || rx_er1 !== 1'b1 || rx_en0 !== 1'b0) begin
      errors++;
      $display("FAIL illegal_rx_er got cyc=%0d rx_dv0=%b rx_er1=%b rx_en0=%b, required cyc=%0d 0 1 0",
               cyc, rx_dv0, rx_er1, rx_en0, at);
    end
    @(negedge clk);
    checks++;
    if (rx_er0 !== 1'b0 || rx_dv0 !== 1'b0) begin
      errors++;
      $display("FAIL illegal_after got rx_er0=%b rx_dv0=%b required 0 0", rx_er0, rx_dv0);
    end
    idle(2);
    send_preamble();
    send_byte(8'h3C);
    idle(6);
    expect_drained("illegal");
    expect_int("illegal_er_pulses0", er_cnt0 - r0, 1);
    expect_int("illegal_er_pulses1", er_cnt1 - r1, 1);
  endtask

  task automatic test_reset_mid();
    int e0;
    send_preamble();
    send_byte(8'hA7);
    drive_nib(4'hC, 1'b1, 1'b1, 1'b1, 1'b1);
    drive_nib(4'h3, 1'b1, 1'b1, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({rx_dv0, rx_en0, rx_data0, rx_er0, crs0, rx_dv1, rx_data1} !== 10'h000) begin
      errors++;
      $display("FAIL reset_mid_async got dv0=%b en0=%b d0=%h er0=%b crs0=%b dv1=%b d1=%h required all 0",
               rx_dv0, rx_en0, rx_data0, rx_er0, crs0, rx_dv1, rx_data1);
    end
    drive_nib(4'h5, 1'b1, 1'b1, 1'b0, 1'b0);
    drive_nib(4'h5, 1'b1, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b1;
    e0 = en_cnt0;
    for (int i = 0; i < 4; i++) drive_nib(4'h5, 1'b1, 1'b1, 1'b0, 1'b0);
    drive_nib(4'hD, 1'b1, 1'b1, 1'b0, 1'b0);
    drive_nib(4'h7, 1'b1, 1'b1, 1'b0, 1'b0);
    drive_nib(4'hA, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(2);
    expect_int("reset_mid_silent0", en_cnt0 - e0, 0);
    send_preamble();
    send_byte(8'h3C);
    send_byte(8'h81);
    idle(6);
    expect_drained("reset_mid");
  endtask

  task automatic test_back_to_back();
    int s0 = rise0, s1 = rise1, r0 = er_cnt0;
    send_preamble();
    send_byte(8'hA7);
    drive_dibit(2'b00, 1'b0);
    drive_dibit(2'b00, 1'b0);
    send_preamble();
    send_byte(8'h3C);
    idle(6);
    expect_drained("b2b");
    expect_int("b2b_dv_rises0", rise0 - s0, 2);
    expect_int("b2b_dv_rises1", rise1 - s1, 2);
    expect_int("b2b_rx_er0", er_cnt0 - r0, 0);
  endtask

  initial begin
    fork
      monitor();
      watchdog();
    join_none
    test_reset();
    test_basic();
    test_strip();
    test_end_toggle();
    test_illegal_end();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
